// File: rtl/c2421_pkg.sv
// Shared definitions for the 2421-code digit receive path: the ten legal
// 2421 code points, the frame decoder state encoding and a legality helper.
package c2421_pkg;

  // Legal 2421 code points; digits 5..9 carry bit 3 set.
  localparam logic [3:0] C2421_D0 = 4'b0000;
  localparam logic [3:0] C2421_D1 = 4'b0001;
  localparam logic [3:0] C2421_D2 = 4'b0010;
  localparam logic [3:0] C2421_D3 = 4'b0011;
  localparam logic [3:0] C2421_D4 = 4'b0100;
  localparam logic [3:0] C2421_D5 = 4'b1011;
  localparam logic [3:0] C2421_D6 = 4'b1100;
  localparam logic [3:0] C2421_D7 = 4'b1101;
  localparam logic [3:0] C2421_D8 = 4'b1110;
  localparam logic [3:0] C2421_D9 = 4'b1111;

  // Frame decoder states: accumulating digits, or presenting a result.
  typedef enum logic {
    ACC = 1'b0,
    OUT = 1'b1
  } state_e;

  // True when code is one of the ten 2421 code points.
  function automatic logic is_legal_2421(input logic [3:0] code);
    logic legal;
    legal = 1'b0;
    case (code)
      C2421_D0, C2421_D1, C2421_D2, C2421_D3, C2421_D4,
      C2421_D5, C2421_D6, C2421_D7, C2421_D8, C2421_D9: legal = 1'b1;
      default:                                          legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/c2421_digit_dec.sv
// Combinational 2421 digit decoder. Legal codes map to 0..9; the six
// unused code points decode to 0 and drop the legal flag so the frame
// logic can record the error.
module c2421_digit_dec
  import c2421_pkg::*;
(
  input  logic [3:0] code_i,
  output logic [3:0] d_o,
  output logic       legal_o
);

  logic       legal;
  logic [3:0] raw_d;

  // Codes with bit 3 set are offset by 6 from their decimal value.
  always_comb begin
    legal = is_legal_2421(code_i);
    raw_d = code_i[3] ? (code_i - 4'd6) : code_i;
    d_o   = legal ? raw_d : 4'd0;
  end

  assign legal_o = legal;

endmodule

// File: rtl/c2421_frame_decoder.sv
// Frame decoder: accepts 2421-coded digits MSD first, accumulates up to
// NDIGITS of them into one binary value and hands the result out over a
// second valid/ready handshake together with error flags and digit count.
module c2421_frame_decoder
  import c2421_pkg::*;
#(
  parameter int NDIGITS = 4,
  parameter int OUT_W   = 14
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [3:0]                     in_digit,
  input  logic                           in_last,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [OUT_W-1:0]               out_value,
  output logic [1:0]                     out_err,
  output logic [$clog2(NDIGITS+1)-1:0]   out_ndigits
);

  localparam int                CNT_W  = $clog2(NDIGITS + 1);
  localparam logic [CNT_W-1:0]  NDIG_C = CNT_W'(NDIGITS);
  localparam logic [OUT_W-1:0]  TEN    = OUT_W'(10);

  // Architectural state
  state_e            state_q, state_d;
  logic [OUT_W-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        err_q, err_d;
  logic              in_ready_q, in_ready_d;
  logic              out_valid_q, out_valid_d;
  logic [OUT_W-1:0]  out_value_q, out_value_d;
  logic [1:0]        out_err_q, out_err_d;
  logic [CNT_W-1:0]  out_ndigits_q, out_ndigits_d;

  // Decoded digit and per-accept helpers
  logic [3:0]        dig_d;
  logic              dig_legal;
  logic              accept;
  logic [OUT_W-1:0]  acc_next;
  logic [CNT_W-1:0]  cnt_inc;
  logic              err0_next;
  logic              close_now;

  c2421_digit_dec u_dec (
    .code_i  (in_digit),
    .d_o     (dig_d),
    .legal_o (dig_legal)
  );

  // Only a registered ready while accumulating can complete an input handshake.
  assign accept    = in_valid && in_ready_q && (state_q == ACC);
  // Width rule on OUT_W guarantees this never wraps for a full frame.
  assign acc_next  = (acc_q * TEN) + OUT_W'(dig_d);
  assign cnt_inc   = cnt_q + CNT_W'(1);
  assign err0_next = err_q[0] | ~dig_legal;
  assign close_now = in_last || (cnt_inc == NDIG_C);

  // State register: every register returns to its idle value on reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ACC;
      acc_q         <= '0;
      cnt_q         <= '0;
      err_q         <= '0;
      in_ready_q    <= 1'b0;
      out_valid_q   <= 1'b0;
      out_value_q   <= '0;
      out_err_q     <= '0;
      out_ndigits_q <= '0;
    end else begin
      state_q       <= state_d;
      acc_q         <= acc_d;
      cnt_q         <= cnt_d;
      err_q         <= err_d;
      in_ready_q    <= in_ready_d;
      out_valid_q   <= out_valid_d;
      out_value_q   <= out_value_d;
      out_err_q     <= out_err_d;
      out_ndigits_q <= out_ndigits_d;
    end
  end

  // Next-state logic: accumulate digits in ACC, hold the result in OUT.
  always_comb begin
    state_d       = state_q;
    acc_d         = acc_q;
    cnt_d         = cnt_q;
    err_d         = err_q;
    out_valid_d   = out_valid_q;
    out_value_d   = out_value_q;
    out_err_d     = out_err_q;
    out_ndigits_d = out_ndigits_q;

    case (state_q)
      ACC: begin
        if (accept) begin
          acc_d = acc_next;
          cnt_d = cnt_inc;
          err_d = {err_q[1], err0_next};
          if (close_now) begin
            // A frame closed by count without in_last is flagged as a runaway.
            err_d[1]      = ~in_last;
            state_d       = OUT;
            out_valid_d   = 1'b1;
            out_value_d   = acc_next;
            out_err_d     = {~in_last, err0_next};
            out_ndigits_d = cnt_inc;
          end
        end
      end
      OUT: begin
        if (out_ready) begin
          // Result consumed: start a fresh frame; no input is taken this cycle.
          state_d     = ACC;
          out_valid_d = 1'b0;
          acc_d       = '0;
          cnt_d       = '0;
          err_d       = '0;
        end
      end
      default: begin
        state_d = ACC;
      end
    endcase

    // Ready follows the next state so it opens one cycle after reset or consume.
    in_ready_d = (state_d == ACC);
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign out_value   = out_value_q;
  assign out_err     = out_err_q;
  assign out_ndigits = out_ndigits_q;

endmodule

// File: tb/tb_c2421_frame_decoder.sv
// Directed bench for the 2421 frame decoder. Inputs change 1 time unit
// after a rising edge and outputs are sampled at that same point.
module tb_c2421_frame_decoder;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_digit;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [13:0] out_value;
  logic [1:0]  out_err;
  logic [2:0]  out_ndigits;

  int checks = 0;
  int errors = 0;

  c2421_frame_decoder #(.NDIGITS(4), .OUT_W(14)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_digit    (in_digit),
    .in_last     (in_last),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_value   (out_value),
    .out_err     (out_err),
    .out_ndigits (out_ndigits)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, obs, exp);
    end else begin
      $display("ok   %s = %0d", tag, obs);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one digit and hold it until accepted; leaves junk on the bus after.
  task automatic send_digit(input logic [3:0] code, input logic last);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_digit = code;
    in_last  = last;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    if (!in_ready) chk("in_ready_timeout", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    in_digit = 4'b0110;
    in_last  = 1'b1;
  endtask

  // Accept one result, waiting a bounded time for out_valid.
  task automatic consume();
    int n;
    n = 0;
    while (!out_valid && n < 50) begin
      tick();
      n++;
    end
    if (!out_valid) chk("out_valid_timeout", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic check_result(input string tag, input int val, input int err, input int nd);
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_value"}, 32'(out_value), 32'(val));
    chk({tag, "_err"}, 32'(out_err), 32'(err));
    chk({tag, "_ndig"}, 32'(out_ndigits), 32'(nd));
    chk({tag, "_rdy"}, 32'(in_ready), 32'd0);
  endtask

  initial begin
    rst       = 1'b0;
    in_valid  = 1'b0;
    in_digit  = 4'd0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    repeat (3) tick();

    // Reset state
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_value", 32'(out_value), 32'd0);
    chk("rst_out_err", 32'(out_err), 32'd0);
    chk("rst_out_ndig", 32'(out_ndigits), 32'd0);
    #4 rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // 1: 1234
    send_digit(4'b0001, 1'b0);
    send_digit(4'b0010, 1'b0);
    send_digit(4'b0011, 1'b0);
    send_digit(4'b0100, 1'b1);
    check_result("t1", 1234, 0, 4);
    consume();
    chk("t1_post_valid", 32'(out_valid), 32'd0);
    chk("t1_post_rdy", 32'(in_ready), 32'd1);

    // 2: 9876
    send_digit(4'b1111, 1'b0);
    send_digit(4'b1110, 1'b0);
    send_digit(4'b1101, 1'b0);
    send_digit(4'b1100, 1'b1);
    check_result("t2", 9876, 0, 4);
    consume();

    // 3: single digit 5 with latency 1
    in_valid = 1'b1;
    in_digit = 4'b1011;
    in_last  = 1'b1;
    chk("t3_pre_valid", 32'(out_valid), 32'd0);
    tick();
    in_valid = 1'b0;
    check_result("t3", 5, 0, 1);
    consume();

    // 4: illegal middle digit -> 103, err 01
    send_digit(4'b0001, 1'b0);
    send_digit(4'b0110, 1'b0);
    send_digit(4'b0011, 1'b1);
    check_result("t4", 103, 1, 3);
    consume();

    // 5: count-close 2222, fifth digit stalled then starts next frame
    repeat (4) send_digit(4'b0010, 1'b0);
    check_result("t5", 2222, 2, 4);
    in_valid = 1'b1;
    in_digit = 4'b0001;
    in_last  = 1'b0;
    tick();
    chk("t5_stall_rdy", 32'(in_ready), 32'd0);
    chk("t5_stall_value", 32'(out_value), 32'd2222);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("t5_consumed_valid", 32'(out_valid), 32'd0);
    tick();
    in_valid = 1'b0;
    send_digit(4'b0000, 1'b1);
    check_result("t5b", 10, 0, 2);
    consume();

    // 6a: out_ready low for 3 cycles holds the result
    send_digit(4'b0100, 1'b0);
    send_digit(4'b0011, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_result($sformatf("t6_hold%0d", i), 43, 0, 2);
    end
    consume();

    // 6b: reset mid-frame after two digits
    send_digit(4'b1111, 1'b0);
    send_digit(4'b1111, 1'b0);
    rst = 1'b0;
    #1;
    chk("t6_rst_valid", 32'(out_valid), 32'd0);
    chk("t6_rst_rdy", 32'(in_ready), 32'd0);
    #3 rst = 1'b1;
    tick();
    send_digit(4'b0100, 1'b1);
    check_result("t6", 4, 0, 1);

    // 6c: reset while in OUT clears the result immediately
    rst = 1'b0;
    #1;
    chk("t6c_rst_valid", 32'(out_valid), 32'd0);
    chk("t6c_rst_value", 32'(out_value), 32'd0);
    chk("t6c_rst_ndig", 32'(out_ndigits), 32'd0);
    #3 rst = 1'b1;
    tick();
    send_digit(4'b0111, 1'b0);
    send_digit(4'b1000, 1'b1);
    check_result("t6c", 0, 1, 2);
    consume();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
